// File: rtl/alu_op_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_issue
// Purpose  : ID->EX issue stage. Decodes MIPS fields into ALU op, shift amount
//            and operand pair, then registers them behind a valid/ready
//            handshake with a one-entry skid buffer and synchronous flush.
// Option   : define ALU_OP_ISSUE_PERF_CNT_EN to add perf_issued/perf_stall.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_issue #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_A,
  output logic [DW-1:0] out_B,
  output logic [2:0]    out_op,
  output logic [4:0]    out_sa,
  output logic          out_illegal
`ifdef ALU_OP_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]   perf_issued,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sll = 3'b011;
  localparam logic [2:0] c_op_srl = 3'b100;
  localparam logic [2:0] c_op_sra = 3'b101;
  localparam logic [2:0] c_op_sub = 3'b110;
  localparam logic [2:0] c_op_slt = 3'b111;

  typedef struct packed {
    logic          ill;
    logic [4:0]    sa;
    logic [2:0]    op;
    logic [DW-1:0] b;
    logic [DW-1:0] a;
  } entry_t;

  logic [5:0]    w_opcode;
  logic [5:0]    w_funct;
  logic [4:0]    w_shamt;
  logic [15:0]   w_imm;
  logic [DW-1:0] w_sext;
  logic [DW-1:0] w_zext;
  logic          w_unused_fields;
  entry_t        w_dec;

  assign w_opcode        = in_instr[31:26];
  assign w_funct         = in_instr[5:0];
  assign w_shamt         = in_instr[10:6];
  assign w_imm           = in_instr[15:0];
  assign w_sext          = {{(DW-16){w_imm[15]}}, w_imm};
  assign w_zext          = {{(DW-16){1'b0}}, w_imm};
  // Register-specifier fields are resolved upstream; only forwarded values are used.
  assign w_unused_fields = ^in_instr[25:16];

  always_comb begin
    w_dec.ill = 1'b0;
    w_dec.sa  = 5'd0;
    w_dec.op  = c_op_add;
    w_dec.a   = in_rs_val;
    w_dec.b   = in_rt_val;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h24:        w_dec.op = c_op_and;
          6'h25:        w_dec.op = c_op_or;
          6'h20, 6'h21: w_dec.op = c_op_add;
          6'h22, 6'h23: w_dec.op = c_op_sub;
          6'h2A:        w_dec.op = c_op_slt;
          6'h00: begin w_dec.op = c_op_sll; w_dec.sa = w_shamt; end
          6'h02: begin w_dec.op = c_op_srl; w_dec.sa = w_shamt; end
          6'h03: begin w_dec.op = c_op_sra; w_dec.sa = w_shamt; end
          6'h04: begin w_dec.op = c_op_sll; w_dec.sa = in_rs_val[4:0]; end
          6'h06: begin w_dec.op = c_op_srl; w_dec.sa = in_rs_val[4:0]; end
          6'h07: begin w_dec.op = c_op_sra; w_dec.sa = in_rs_val[4:0]; end
          default:      w_dec.ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin w_dec.op = c_op_add; w_dec.b = w_sext; end
      6'h0A:        begin w_dec.op = c_op_slt; w_dec.b = w_sext; end
      6'h0C:        begin w_dec.op = c_op_and; w_dec.b = w_zext; end
      6'h0D:        begin w_dec.op = c_op_or;  w_dec.b = w_zext; end
      6'h23, 6'h2B: begin w_dec.op = c_op_add; w_dec.b = w_sext; end
      6'h04, 6'h05: w_dec.op = c_op_sub;
      6'h0F: begin
        w_dec.op = c_op_sll;
        w_dec.a  = '0;
        w_dec.b  = w_zext;
        w_dec.sa = 5'd16;
      end
      default:      w_dec.ill = 1'b1;
    endcase
    // Undecodable words issue as a harmless add of zeros.
    if (w_dec.ill) begin
      w_dec.op = c_op_add;
      w_dec.a  = '0;
      w_dec.b  = '0;
      w_dec.sa = 5'd0;
    end
  end

  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   w_accept;
  logic   w_m_free;

  assign w_accept = in_valid && !s_valid_q;
  assign w_m_free = !m_valid_q || out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (w_m_free) begin
      // in_ready is low whenever S is occupied, so no input competes with the S->M move.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = w_accept;
        if (w_accept) m_d = w_dec;
      end
    end else if (w_accept) begin
      s_d       = w_dec;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign in_ready    = !s_valid_q;
  assign out_valid   = m_valid_q;
  assign out_A       = m_q.a;
  assign out_B       = m_q.b;
  assign out_op      = m_q.op;
  assign out_sa      = m_q.sa;
  assign out_illegal = m_valid_q && m_q.ill;

`ifdef ALU_OP_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (m_valid_q && out_ready)  perf_issued_q <= perf_issued_q + 32'd1;
      if (m_valid_q && !out_ready) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire
